// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline interlock controller: scoreboard entries and
// the mult/div sequencer state encoding.
package hazard_controller_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dest: REG_ZERO, is_load: 1'b0};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_t;

  // True when a valid ID instruction reads the register an in-flight entry will write.
  function automatic logic src_match(sb_entry_t e, logic id_valid,
                                     logic uses_rs, logic [4:0] rs,
                                     logic uses_rt, logic [4:0] rt);
    return e.valid & id_valid & ((uses_rs & (rs == e.dest)) | (uses_rt & (rt == e.dest)));
  endfunction

endpackage

// File: rtl/hazard_controller_muldiv_sequencer.sv
// Multi-cycle mult/div sequencer: tracks unit occupancy from issue until the
// HI/LO result becomes valid.
module hazard_controller_muldiv_sequencer
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic issue,
  output logic muldiv_start,
  output logic muldiv_busy,
  output logic hilo_valid
);

  localparam int unsigned CntW = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;

  md_state_t       state;
  logic [CntW-1:0] cnt;

  assign muldiv_start = issue & (state == StIdle);

  // Issue cycle + (LATENCY-2) BUSY countdown + 1 -> DONE lands LATENCY cycles after issue.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= StIdle;
      cnt         <= '0;
      muldiv_busy <= 1'b0;
      hilo_valid  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (issue) begin
            state       <= StBusy;
            cnt         <= CntW'(MULDIV_LATENCY - 2);
            muldiv_busy <= 1'b1;
          end
        end
        StBusy: begin
          if (cnt == '0) begin
            state      <= StDone;
            hilo_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StDone: begin
          state       <= StIdle;
          hilo_valid  <= 1'b0;
          muldiv_busy <= 1'b0;
        end
        default: begin
          state       <= StIdle;
          muldiv_busy <= 1'b0;
          hilo_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline interlock controller: scoreboard of in-flight destinations, hazard
// detection for stalls the forwarding network cannot cover, and mult/div sequencing.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 4,
  parameter int unsigned STALL_CNT_W    = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ID_Valid,
  input  logic [4:0]             ID_rs,
  input  logic [4:0]             ID_rt,
  input  logic                   ID_uses_rs,
  input  logic                   ID_uses_rt,
  input  logic [4:0]             ID_dest,
  input  logic                   ID_reg_write,
  input  logic                   ID_load,
  input  logic                   ID_branch_jr,
  input  logic                   ID_muldiv,
  input  logic                   ID_hilo_read,
  input  logic                   Redirect,
  output logic                   stall,
  output logic                   bubble_EXE,
  output logic                   flush_IF,
  output logic                   muldiv_start,
  output logic                   muldiv_busy,
  output logic                   hilo_valid,
  output logic [STALL_CNT_W-1:0] stall_count
);

  sb_entry_t sb_exe, sb_mem, sb_wb;
  logic      match_exe, match_mem;
  logic      load_use_haz, branch_haz, muldiv_haz;
  logic      issue;

  assign match_exe = src_match(sb_exe, ID_Valid, ID_uses_rs, ID_rs, ID_uses_rt, ID_rt);
  assign match_mem = src_match(sb_mem, ID_Valid, ID_uses_rs, ID_rs, ID_uses_rt, ID_rt);

  assign load_use_haz = match_exe & sb_exe.is_load;
  // Non-load MEM results and anything in WB reach ID through forwarding.
  assign branch_haz   = ID_branch_jr & (match_exe | (match_mem & sb_mem.is_load));
  assign muldiv_haz   = (ID_muldiv | ID_hilo_read) & ID_Valid & muldiv_busy;

  assign stall      = load_use_haz | branch_haz | muldiv_haz;
  assign bubble_EXE = stall;
  assign flush_IF   = Redirect & ~stall & ~RESET;
  assign issue      = ID_Valid & ID_muldiv & ~stall & ~RESET;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sb_exe <= SB_EMPTY;
      sb_mem <= SB_EMPTY;
      sb_wb  <= SB_EMPTY;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_exe;
      if (ID_Valid & ID_reg_write & (ID_dest != REG_ZERO) & ~stall) begin
        sb_exe <= '{valid: 1'b1, dest: ID_dest, is_load: ID_load};
      end else begin
        sb_exe <= SB_EMPTY;
      end
    end
  end

  // WB is tracked for completeness of the pipeline view but never causes a stall.
  logic unused_wb;
  assign unused_wb = ^sb_wb;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  hazard_controller_muldiv_sequencer #(
    .MULDIV_LATENCY(MULDIV_LATENCY)
  ) u_muldiv_sequencer (
    .CLK         (CLK),
    .RESET       (RESET),
    .issue       (issue),
    .muldiv_start(muldiv_start),
    .muldiv_busy (muldiv_busy),
    .hilo_valid  (hilo_valid)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench: each stimulus cycle queues its expected outputs; a negedge
// monitor pops and compares them against the DUT.
module tb_hazard_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ID_Valid, ID_uses_rs, ID_uses_rt, ID_reg_write, ID_load;
  logic        ID_branch_jr, ID_muldiv, ID_hilo_read, Redirect;
  logic [4:0]  ID_rs, ID_rt, ID_dest;
  logic        stall, bubble_EXE, flush_IF, muldiv_start, muldiv_busy, hilo_valid;
  logic [15:0] stall_count;

  hazard_controller #(
    .MULDIV_LATENCY(4),
    .STALL_CNT_W   (16)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ID_Valid    (ID_Valid),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .ID_uses_rs  (ID_uses_rs),
    .ID_uses_rt  (ID_uses_rt),
    .ID_dest     (ID_dest),
    .ID_reg_write(ID_reg_write),
    .ID_load     (ID_load),
    .ID_branch_jr(ID_branch_jr),
    .ID_muldiv   (ID_muldiv),
    .ID_hilo_read(ID_hilo_read),
    .Redirect    (Redirect),
    .stall       (stall),
    .bubble_EXE  (bubble_EXE),
    .flush_IF    (flush_IF),
    .muldiv_start(muldiv_start),
    .muldiv_busy (muldiv_busy),
    .hilo_valid  (hilo_valid),
    .stall_count (stall_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dest;
    logic       rw, ld, bj, md, hr;
  } instr_t;

  typedef struct packed {
    logic        stall, flush, start, busy, hilo;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;

  function automatic instr_t i_nop();
    return '0;
  endfunction
  function automatic instr_t i_lw(logic [4:0] d, logic [4:0] base);
    instr_t i = '0;
    i.valid = 1; i.rs = base; i.urs = 1; i.dest = d; i.rw = 1; i.ld = 1;
    return i;
  endfunction
  function automatic instr_t i_alu(logic [4:0] d, logic [4:0] s, logic [4:0] t);
    instr_t i = '0;
    i.valid = 1; i.rs = s; i.rt = t; i.urs = 1; i.urt = 1; i.dest = d; i.rw = 1;
    return i;
  endfunction
  function automatic instr_t i_beq(logic [4:0] s, logic [4:0] t);
    instr_t i = '0;
    i.valid = 1; i.rs = s; i.rt = t; i.urs = 1; i.urt = 1; i.bj = 1;
    return i;
  endfunction
  function automatic instr_t i_mult(logic [4:0] s, logic [4:0] t);
    instr_t i = '0;
    i.valid = 1; i.rs = s; i.rt = t; i.urs = 1; i.urt = 1; i.md = 1;
    return i;
  endfunction
  function automatic instr_t i_mflo(logic [4:0] d);
    instr_t i = '0;
    i.valid = 1; i.dest = d; i.rw = 1; i.hr = 1;
    return i;
  endfunction

  function automatic exp_t x(logic s, logic f, logic st, logic b, logic h, int c);
    exp_t e;
    e.stall = s; e.flush = f; e.start = st; e.busy = b; e.hilo = h; e.cnt = 16'(c);
    return e;
  endfunction

  task automatic drive(input instr_t i, input logic redir);
    ID_Valid = i.valid; ID_rs = i.rs; ID_rt = i.rt; ID_uses_rs = i.urs; ID_uses_rt = i.urt;
    ID_dest = i.dest; ID_reg_write = i.rw; ID_load = i.ld; ID_branch_jr = i.bj;
    ID_muldiv = i.md; ID_hilo_read = i.hr; Redirect = redir;
  endtask

  // One ID cycle; rst_mid raises RESET between edges to observe it acting asynchronously.
  task automatic step(input instr_t i, input logic redir, input logic rst_mid,
                      input exp_t e, input string nm);
    drive(i, redir);
    if (rst_mid) begin
      #1;
      RESET = 1'b1;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  exp_t        mon_e;
  string       mon_nm;
  logic [21:0] mon_got, mon_want;

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e    = exp_q.pop_front();
      mon_nm   = name_q.pop_front();
      mon_got  = {stall, bubble_EXE, flush_IF, muldiv_start, muldiv_busy, hilo_valid,
                  stall_count};
      mon_want = {mon_e.stall, mon_e.stall, mon_e.flush, mon_e.start, mon_e.busy, mon_e.hilo,
                  mon_e.cnt};
      total++;
      if (mon_got !== mon_want) begin
        bad++;
        $display("FAIL %s: got stall,bubble,flush,start,busy,hilo=%b cnt=%0d, want %b cnt=%0d",
                 mon_nm, mon_got[21:16], mon_got[15:0], mon_want[21:16], mon_want[15:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    drive(i_nop(), 1'b0);
    @(posedge CLK);
    #1;
    step(i_nop(), 1, 0, x(0, 0, 0, 0, 0, 0), "reset_outputs");
    RESET = 1'b0;

    // Load-use
    step(i_lw(8, 29),     0, 0, x(0, 0, 0, 0, 0, 0), "lu_lw");
    step(i_alu(9, 8, 10), 0, 0, x(1, 0, 0, 0, 0, 0), "lu_stall");
    step(i_alu(9, 8, 10), 0, 0, x(0, 0, 0, 0, 0, 1), "lu_release");
    step(i_nop(),         0, 0, x(0, 0, 0, 0, 0, 1), "lu_cnt");
    // Forwardable ALU dependence
    step(i_alu(8, 1, 2),  0, 0, x(0, 0, 0, 0, 0, 1), "fwd_add");
    step(i_alu(9, 8, 1),  0, 0, x(0, 0, 0, 0, 0, 1), "fwd_no_stall");
    step(i_nop(),         0, 0, x(0, 0, 0, 0, 0, 1), "fwd_nop");
    // ALU then branch, with redirect during and after the stall
    step(i_alu(8, 1, 2),  0, 0, x(0, 0, 0, 0, 0, 1), "br_alu_add");
    step(i_beq(8, 0),     1, 0, x(1, 0, 0, 0, 0, 1), "br_alu_stall_noflush");
    step(i_beq(8, 0),     1, 0, x(0, 1, 0, 0, 0, 2), "br_alu_go_flush");
    step(i_nop(),         0, 0, x(0, 0, 0, 0, 0, 2), "br_alu_nop");
    // Load then branch: two stalls
    step(i_lw(8, 29),     0, 0, x(0, 0, 0, 0, 0, 2), "br_lw_lw");
    step(i_beq(8, 0),     0, 0, x(1, 0, 0, 0, 0, 2), "br_lw_stall1");
    step(i_beq(8, 0),     0, 0, x(1, 0, 0, 0, 0, 3), "br_lw_stall2");
    step(i_beq(8, 0),     0, 0, x(0, 0, 0, 0, 0, 4), "br_lw_go");
    step(i_nop(),         0, 0, x(0, 0, 0, 0, 0, 4), "br_lw_nop");
    // Load, nop, branch: one stall
    step(i_lw(8, 29),     0, 0, x(0, 0, 0, 0, 0, 4), "br_lwn_lw");
    step(i_nop(),         0, 0, x(0, 0, 0, 0, 0, 4), "br_lwn_nop");
    step(i_beq(8, 0),     0, 0, x(1, 0, 0, 0, 0, 4), "br_lwn_stall");
    step(i_beq(8, 0),     0, 0, x(0, 0, 0, 0, 0, 5), "br_lwn_go");
    step(i_nop(),         0, 0, x(0, 0, 0, 0, 0, 5), "br_lwn_tail");
    // Register 0 never matches
    step(i_lw(0, 29),     0, 0, x(0, 0, 0, 0, 0, 5), "r0_lw");
    step(i_alu(1, 0, 0),  0, 0, x(0, 0, 0, 0, 0, 5), "r0_no_stall");
    step(i_nop(),         0, 0, x(0, 0, 0, 0, 0, 5), "r0_nop");
    // mult then mflo, latency 4
    step(i_mult(2, 3),    0, 0, x(0, 0, 1, 0, 0, 5), "md_issue");
    step(i_mflo(4),       0, 0, x(1, 0, 0, 1, 0, 5), "md_stall1");
    step(i_mflo(4),       0, 0, x(1, 0, 0, 1, 0, 6), "md_stall2");
    step(i_mflo(4),       0, 0, x(1, 0, 0, 1, 0, 7), "md_stall3");
    step(i_mflo(4),       0, 0, x(1, 0, 0, 1, 1, 8), "md_done_stall");
    step(i_mflo(4),       0, 0, x(0, 0, 0, 0, 0, 9), "md_mflo_go");
    step(i_nop(),         0, 0, x(0, 0, 0, 0, 0, 9), "md_nop");
    // Load-use and mult/div hazard together count as one stall
    step(i_mult(2, 3),    0, 0, x(0, 0, 1, 0, 0, 9),  "both_issue");
    step(i_lw(8, 29),     0, 0, x(0, 0, 0, 1, 0, 9),  "both_lw");
    step(i_mult(8, 3),    0, 0, x(1, 0, 0, 1, 0, 9),  "both_single_stall");
    step(i_mult(8, 3),    0, 0, x(1, 0, 0, 1, 0, 10), "both_busy_stall");
    step(i_mult(8, 3),    0, 0, x(1, 0, 0, 1, 1, 11), "both_done_stall");
    step(i_mult(8, 3),    0, 0, x(0, 0, 1, 0, 0, 12), "both_reissue");
    step(i_nop(),         0, 0, x(0, 0, 0, 1, 0, 12), "drain_busy1");
    step(i_nop(),         0, 0, x(0, 0, 0, 1, 0, 12), "drain_busy2");
    step(i_nop(),         0, 0, x(0, 0, 0, 1, 0, 12), "drain_busy3");
    step(i_nop(),         0, 0, x(0, 0, 0, 1, 1, 12), "drain_done");
    // mult blocked by load-use does not start the sequencer
    step(i_lw(8, 29),     0, 0, x(0, 0, 0, 0, 0, 12), "blk_lw");
    step(i_mult(8, 3),    0, 0, x(1, 0, 0, 0, 0, 12), "blk_no_start");
    step(i_mult(8, 3),    0, 0, x(0, 0, 1, 0, 0, 13), "blk_start");
    // Asynchronous reset mid-BUSY with a pending mflo stall
    step(i_mflo(4),       0, 1, x(0, 0, 0, 0, 0, 0),  "rst_mid_busy");
    RESET = 1'b0;
    step(i_lw(8, 29),     0, 0, x(0, 0, 0, 0, 0, 0),  "rst_post_lw");
    step(i_alu(9, 8, 10), 0, 1, x(0, 0, 0, 0, 0, 0),  "rst_during_loaduse");
    RESET = 1'b0;
    step(i_alu(9, 8, 10), 0, 0, x(0, 0, 0, 0, 0, 0),  "rst_sb_empty");
    step(i_nop(),         0, 0, x(0, 0, 0, 0, 0, 0),  "tail");

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
